// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 codes and store lane helpers for the MEM-stage LSU.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        case (funct3)
            F3_SB:   be = 4'b0001 << off;
            F3_SH:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Loads decode size from funct3[1:0] (bit 2 is signedness); stores only know SB/SH.
    function automatic logic [1:0] op_size(input logic [2:0] funct3, input logic store);
        logic [1:0] sz;
        if (store) begin
            case (funct3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (funct3[1:0])
                2'b00:   sz = SZ_BYTE;
                2'b01:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword of a bus read word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] data
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_byte = byte_lane[off];
        sel_half = off[1] ? rdata[31:16] : rdata[15:0];
        case (op_size(funct3, 1'b0))
            SZ_BYTE: data = {{24{sel_byte[7] & ~funct3[2]}}, sel_byte};
            SZ_HALF: data = {{16{sel_half[15] & ~funct3[2]}}, sel_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid bus master that stalls the pipe until completion.
// Optional LSU_MISALIGN_TRAP_EN suppresses misaligned accesses and exposes misaligned_o.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] dataR_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        misaligned_o
`endif
);

    localparam logic [8:0] MAX_WAIT_W = 9'(MAX_WAIT);

    lsu_state_e  state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;

    logic        access;
    logic        access_go;
    logic        is_store;
    logic        is_load;
    logic        timeout;
    logic [31:0] load_data;

    assign access   = valid_i & (mem_read_i | mem_write_i);
    assign is_store = mem_write_i;
    assign is_load  = valid_i & mem_read_i & ~mem_write_i;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;

    always_comb begin
        case (op_size(funct3_i, is_store))
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_i[0];
            default: misaligned = |addr_i[1:0];
        endcase
    end

    assign misaligned_o = access & misaligned;
    assign access_go    = access & ~misaligned;
`else
    assign access_go    = access;
`endif

    // Fires on the last permitted pending cycle so DONE lands exactly MAX_WAIT cycles in.
    assign timeout = ({1'b0, cnt_reg} + 9'd1) == MAX_WAIT_W;

    assign bus_addr_o = {addr_i[31:2], 2'b00};
    assign bus_be_o   = is_store ? store_be(funct3_i, addr_i[1:0]) : 4'b1111;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wlane
            assign bus_wdata_o[8*gi +: 8] = (funct3_i == F3_SB) ? wdata_i[7:0] :
                                            (funct3_i == F3_SH) ? wdata_i[8*(gi%2) +: 8] :
                                                                  wdata_i[8*gi +: 8];
        end
    endgenerate

    lsu_load_align u_align (
        .rdata  (rdata_reg),
        .funct3 (funct3_i),
        .off    (addr_i[1:0]),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (access_go) begin
                    cnt_next = cnt_reg + 8'd1;
                    if (is_load && bus_rvalid_i) begin
                        rdata_next = bus_rdata_i;
                    end
                    if (bus_gnt_i && (is_store || bus_rvalid_i)) begin
                        state_next = DONE;
                    end else if (timeout) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end else if (bus_gnt_i) begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + 8'd1;
                if (bus_rvalid_i) begin
                    rdata_next = bus_rdata_i;
                    state_next = DONE;
                end else if (timeout) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                    rdata_next = '0;
                end
            end
            DONE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Gating on rst drops the request the moment reset rises, even with inputs still held.
    always_comb begin
        bus_req_o = 1'b0;
        bus_we_o  = 1'b0;
        stall_o   = 1'b0;
        bus_err_o = 1'b0;
        dataR_o   = '0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    bus_req_o = access_go;
                    bus_we_o  = access_go & is_store;
                    stall_o   = access_go;
                end
                WAIT: begin
                    stall_o = 1'b1;
                end
                DONE: begin
                    bus_err_o = err_reg;
                    dataR_o   = is_load ? load_data : 32'd0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage RV32I pipeline.
- Sits between the EX/MEM register and the MEM/WB register.
- Converts an EX-stage memory op into a req/gnt/rvalid data-bus transaction and stalls the pipeline until the transaction completes.
- Produces the aligned, sign/zero-extended load word that the MEM/WB register captures as its read-data input.

Parameters:
- MAX_WAIT, 15: bus cycles allowed from first request to completion before a timeout bus error; 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_i  in  1  EX/MEM slot holds a real instruction
- mem_read_i  in  1  load
- mem_write_i  in  1  store
- funct3_i  in  3  RV32I width/sign code
- addr_i  in  32  effective address (ALU result)
- wdata_i  in  32  store data (rs2), unaligned
- stall_o  out  1  freeze PC/IF/ID/EX/EX-MEM; MEM/WB inserts a bubble
- dataR_o  out  32  formatted load data
- bus_err_o  out  1  one-cycle pulse, access timed out
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word address, {addr_i[31:2],2'b00}
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-replicated store data
- bus_gnt_i  in  1  request accepted
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  read data

Behaviour:
- access = valid_i & (mem_read_i | mem_write_i). While stall_o=1, upstream holds every *_i input stable; bus outputs are combinational from the inputs.
- FSM states:
  - IDLE: bus_req_o = access; stall_o = access.
    - gnt on a store -> DONE.
    - gnt on a load with rvalid the same cycle -> DONE.
    - gnt on a load without rvalid -> WAIT.
    - no gnt -> stay in IDLE, counting.
  - WAIT: bus_req_o=0; stall_o=1; rvalid -> DONE.
  - DONE: bus_req_o=0; stall_o=0 (the instruction advances at this edge); -> IDLE.
- Timeout:
  - Counter cleared in DONE; increments each cycle an access is pending in IDLE or WAIT.
  - When it reaches MAX_WAIT without completion -> DONE, bus_err_o=1 for that DONE cycle, rdata register loaded with 0.
- rdata register:
  - Captures bus_rdata_i on rvalid in IDLE or WAIT.
  - dataR_o is valid in DONE and equals 0 in every other state or for non-load ops.
- Load format (byte offset b=addr_i[1:0]):
  - LB 000 / LBU 100: byte b, sign- or zero-extended.
  - LH 001 / LHU 101: halfword addr_i[1], sign- or zero-extended.
  - LW 010: full word.
  - Other funct3 values: treated as LW.
- Store lanes:
  - SB: be = 4'b0001<<b, wdata = {4{wdata_i[7:0]}}.
  - SH: be = addr_i[1] ? 1100 : 0011, wdata = {2{wdata_i[15:0]}}.
  - SW: be = 1111.
  - Loads: be = 1111.
- Non-memory or invalid slot: no request, stall_o=0, dataR_o=0.
- mem_read_i & mem_write_i both 1: treated as a store.
- Late bus responses are ignored: gnt outside IDLE, rvalid outside IDLE/WAIT.
- Reset: async to IDLE, counter 0, rdata register 0. All outputs 0 except bus_addr_o, bus_wdata_o, bus_be_o, which follow the inputs. Reset mid-transaction drops bus_req_o immediately.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned = halfword with addr_i[0]=1, or word with addr_i[1:0]!=0.
  - No bus request is issued, stall_o=0, dataR_o=0.
  - Extra output misaligned_o = access & misaligned, combinational.
- Undefined:
  - No misaligned_o port.
  - Halfword ignores addr_i[0]; word ignores addr_i[1:0]; the access proceeds aligned.

Decomposition:
- lsu_pkg:
  - state enum {IDLE, WAIT, DONE}.
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - Function store_be(funct3, off).
- Sub-module lsu_load_align: combinational rdata + funct3 + offset -> dataR. Instantiated once; reused by the verification model.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, gnt in first cycle -> req/we=1, be=1111, addr=0x100; stall_o high one cycle, DONE next cycle, stall_o low.
- LB addr 0x203, gnt at cycle 0, rvalid at cycle 2 with rdata 0x80123456 -> stall_o high for 3 cycles; DONE dataR_o=0xFFFFFF80. Same access with LBU -> 0x00000080.
- SH addr 0x302, wdata 0x0000ABCD -> be=1100, bus_wdata=0xABCDABCD.
- Load with gnt withheld, MAX_WAIT=15 -> DONE entered exactly 15 cycles after request start; bus_err_o one pulse; dataR_o=0.
- rst asserted while in WAIT -> stall_o/bus_req_o to 0 asynchronously; an rvalid after reset release is ignored; the next load completes normally.
- LSU_MISALIGN_TRAP_EN, LW addr 0x101 -> misaligned_o=1, no bus_req_o, stall_o=0. Without the macro -> bus_addr_o=0x100, normal completion.
